// File: rtl/hwpe_stream_copy_source_multi.sv
// -----------------------------------------------------------------------------
// hwpe_stream_copy_source_multi
//
// Multi-channel, time-shifted copy source for lockstep fault detection on
// HWPE streams. Each channel mirrors a monitored normal stream onto a copy
// stream, DELAY cycles later. It then checks the ready returned by the copy
// network against the normal-stream ready, delayed by the same amount.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   enable_i        1: checking active; 0: compare masked, counter holds
//   normal_*_i      monitored normal stream per channel (valid/ready/data/strb)
//   copy_*_o        copy stream per channel (valid/data/strb driven)
//   copy_ready_i    ready sampled back from the copy network
//   clear_fault_i   per-channel sticky-fault clear pulse
//   clear_cnt_i     clears fault counter and alarm
//   fault_o         registered live mismatch, 1 cycle after the compare
//   sticky_fault_o  latched fault per channel until cleared
//   fault_count_o   saturating count of cycles with >=1 channel mismatch
//   alarm_o         registered: fault count >= ALARM_THRESHOLD
// -----------------------------------------------------------------------------
module hwpe_stream_copy_source_multi #(
    parameter int unsigned NB_CHAN          = 2,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned DELAY            = 1,
    parameter int unsigned CHECK_VALID_ONLY = 1,
    parameter int unsigned CNT_WIDTH        = 8,
    parameter int unsigned ALARM_THRESHOLD  = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     enable_i,
    input  logic [NB_CHAN-1:0]                       normal_valid_i,
    input  logic [NB_CHAN-1:0]                       normal_ready_i,
    input  logic [NB_CHAN-1:0][DATA_WIDTH-1:0]       normal_data_i,
    input  logic [NB_CHAN-1:0][DATA_WIDTH/8-1:0]     normal_strb_i,
    output logic [NB_CHAN-1:0]                       copy_valid_o,
    input  logic [NB_CHAN-1:0]                       copy_ready_i,
    output logic [NB_CHAN-1:0][DATA_WIDTH-1:0]       copy_data_o,
    output logic [NB_CHAN-1:0][DATA_WIDTH/8-1:0]     copy_strb_o,
    input  logic [NB_CHAN-1:0]                       clear_fault_i,
    input  logic                                     clear_cnt_i,
    output logic [NB_CHAN-1:0]                       fault_o,
    output logic [NB_CHAN-1:0]                       sticky_fault_o,
    output logic [CNT_WIDTH-1:0]                     fault_count_o,
    output logic                                     alarm_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    // One delay-line word carries {ready, valid, data, strb}; the ready bit
    // is the reference the copy-network ready gets compared against.
    localparam int unsigned LINE_WIDTH = 2 + DATA_WIDTH + STRB_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [CNT_WIDTH-1:0] ALARM_THRESH = CNT_WIDTH'(ALARM_THRESHOLD);
    localparam logic                 VALID_GATED  = (CHECK_VALID_ONLY != 0);

    logic [NB_CHAN-1:0]   ref_ready;
    logic [NB_CHAN-1:0]   valid_gate;
    logic [NB_CHAN-1:0]   mm;
    logic [NB_CHAN-1:0]   fault_reg;
    logic [NB_CHAN-1:0]   sticky_reg;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 alarm_reg;

    // -------------------------------------------------------------------------
    // Per-channel copy path and ready history
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NB_CHAN; gi++) begin : gen_chan
        logic [LINE_WIDTH-1:0] line_in;

        assign line_in = {normal_ready_i[gi], normal_valid_i[gi],
                          normal_data_i[gi], normal_strb_i[gi]};

        if (DELAY == 0) begin : gen_pass
            assign {ref_ready[gi], copy_valid_o[gi],
                    copy_data_o[gi], copy_strb_o[gi]} = line_in;
        end else begin : gen_delay
            logic [LINE_WIDTH-1:0] stage_reg [DELAY];

            // Stage 0 samples the normal stream every cycle regardless of
            // handshake, so the copy is a pure time shift of the wires.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int s = 0; s < int'(DELAY); s++) begin
                        stage_reg[s] <= '0;
                    end
                end else begin
                    stage_reg[0] <= line_in;
                    for (int s = 1; s < int'(DELAY); s++) begin
                        stage_reg[s] <= stage_reg[s-1];
                    end
                end
            end

            assign {ref_ready[gi], copy_valid_o[gi],
                    copy_data_o[gi], copy_strb_o[gi]} = stage_reg[DELAY-1];
        end
    end

    // -------------------------------------------------------------------------
    // Compare
    // -------------------------------------------------------------------------
    assign valid_gate = VALID_GATED ? copy_valid_o : {NB_CHAN{1'b1}};
    assign mm         = {NB_CHAN{enable_i}} & (copy_ready_i ^ ref_ready) & valid_gate;

    // Counter: clear takes priority but still records a mismatch seen in the
    // same cycle; otherwise saturate instead of wrapping.
    always_comb begin
        count_next = count_reg;
        if (clear_cnt_i) begin
            count_next = CNT_WIDTH'(|mm);
        end else if ((|mm) && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_reg  <= '0;
            sticky_reg <= '0;
            count_reg  <= '0;
            alarm_reg  <= 1'b0;
        end else begin
            fault_reg  <= mm;
            // A new mismatch wins over a clear arriving in the same cycle.
            sticky_reg <= mm | (sticky_reg & ~clear_fault_i);
            count_reg  <= count_next;
            alarm_reg  <= (count_next >= ALARM_THRESH);
        end
    end

    assign fault_o        = fault_reg;
    assign sticky_fault_o = sticky_reg;
    assign fault_count_o  = count_reg;
    assign alarm_o        = alarm_reg;

endmodule

// File: tb/tb_hwpe_stream_copy_source_multi.sv
// -----------------------------------------------------------------------------
// Testbench for hwpe_stream_copy_source_multi.
// Three instances with different DELAY / CHECK_VALID_ONLY / CNT_WIDTH /
// ALARM_THRESHOLD share one stimulus. A reference model keeps a history queue
// of sampled normal-stream beats and derives every expected output from it.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_copy_source_multi;

    localparam int NI = 3;
    localparam int unsigned D_P   [NI] = '{1, 2, 0};
    localparam int unsigned CVO_P [NI] = '{1, 0, 1};
    localparam int unsigned CW_P  [NI] = '{3, 8, 4};
    localparam int unsigned TH_P  [NI] = '{4, 4, 5};

    typedef struct packed {
        logic [1:0]       v;
        logic [1:0]       r;
        logic [1:0][31:0] d;
        logic [1:0][3:0]  s;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       nv, nr, cr, clr_f;
    logic [1:0][31:0] nd;
    logic [1:0][3:0]  ns;
    logic             clr_c;

    logic [1:0]       o_cv     [NI];
    logic [1:0][31:0] o_cd     [NI];
    logic [1:0][3:0]  o_cs     [NI];
    logic [1:0]       o_fault  [NI];
    logic [1:0]       o_sticky [NI];
    logic [7:0]       o_cnt    [NI];
    logic             o_alarm  [NI];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic [CW_P[gi]-1:0] cnt;

        hwpe_stream_copy_source_multi #(
            .NB_CHAN          (2),
            .DATA_WIDTH       (32),
            .DELAY            (D_P[gi]),
            .CHECK_VALID_ONLY (CVO_P[gi]),
            .CNT_WIDTH        (CW_P[gi]),
            .ALARM_THRESHOLD  (TH_P[gi])
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .enable_i       (en),
            .normal_valid_i (nv),
            .normal_ready_i (nr),
            .normal_data_i  (nd),
            .normal_strb_i  (ns),
            .copy_valid_o   (o_cv[gi]),
            .copy_ready_i   (cr),
            .copy_data_o    (o_cd[gi]),
            .copy_strb_o    (o_cs[gi]),
            .clear_fault_i  (clr_f),
            .clear_cnt_i    (clr_c),
            .fault_o        (o_fault[gi]),
            .sticky_fault_o (o_sticky[gi]),
            .fault_count_o  (cnt),
            .alarm_o        (o_alarm[gi])
        );

        assign o_cnt[gi] = 8'(cnt);
    end

    // ------------------------------------------------------------------ model
    beat_t      hist[$];
    logic [1:0] m_fault  [NI];
    logic [1:0] m_sticky [NI];
    int         m_count  [NI];
    logic       m_alarm  [NI];

    function automatic beat_t cur_in();
        beat_t b;
        b.v = nv; b.r = nr; b.d = nd; b.s = ns;
        return b;
    endfunction

    // What the normal stream looked like d cycles ago; zeros before reset ends.
    function automatic beat_t delayed(int d);
        if (d == 0) return cur_in();
        if (hist.size() < d) return '0;
        return hist[hist.size() - d];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < NI; i++) begin
            m_fault[i] = '0; m_sticky[i] = '0; m_count[i] = 0; m_alarm[i] = 1'b0;
        end
    endtask

    // One clock cycle: check all outputs mid-cycle, then advance the model.
    task automatic cycle();
        beat_t      cur, dl;
        logic [1:0] mm;
        logic [1:0] n_fault  [NI];
        logic [1:0] n_sticky [NI];
        int         n_count  [NI];
        logic       n_alarm  [NI];
        int         sat;
        @(negedge clk);
        $display("cyc %0d rst=%b en=%b nv=%b nr=%b cr=%b clrf=%b clrc=%b cnt=%0d/%0d/%0d",
                 cyc, rst, en, nv, nr, cr, clr_f, clr_c, o_cnt[0], o_cnt[1], o_cnt[2]);
        cur = cur_in();
        for (int i = 0; i < NI; i++) begin
            dl = delayed(int'(D_P[i]));
            chk($sformatf("i%0d copy_valid", i), 64'(o_cv[i]),     64'(dl.v));
            chk($sformatf("i%0d copy_data",  i), 64'(o_cd[i]),     64'(dl.d));
            chk($sformatf("i%0d copy_strb",  i), 64'(o_cs[i]),     64'(dl.s));
            chk($sformatf("i%0d fault",      i), 64'(o_fault[i]),  64'(m_fault[i]));
            chk($sformatf("i%0d sticky",     i), 64'(o_sticky[i]), 64'(m_sticky[i]));
            chk($sformatf("i%0d count",      i), 64'(o_cnt[i]),    64'(m_count[i]));
            chk($sformatf("i%0d alarm",      i), 64'(o_alarm[i]),  64'(m_alarm[i]));
            mm = en ? ((cr ^ dl.r) & ((CVO_P[i] != 0) ? dl.v : 2'b11)) : 2'b00;
            sat = (1 << CW_P[i]) - 1;
            n_fault[i]  = mm;
            n_sticky[i] = mm | (m_sticky[i] & ~clr_f);
            if (clr_c)            n_count[i] = (mm != 0) ? 1 : 0;
            else if (mm != 0)     n_count[i] = (m_count[i] < sat) ? m_count[i] + 1 : sat;
            else                  n_count[i] = m_count[i];
            n_alarm[i] = (n_count[i] >= int'(TH_P[i]));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                m_fault[i] = n_fault[i]; m_sticky[i] = n_sticky[i];
                m_count[i] = n_count[i]; m_alarm[i] = n_alarm[i];
            end
            hist.push_back(cur);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        cyc++;
        #1;
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        model_reset();
        rst = 1'b1; en = 1'b0; nv = '0; nr = '0; nd = '0; ns = '0;
        cr = '0; clr_f = '0; clr_c = 1'b0;
        #1;
        cycle(); cycle();
        chk("reset count", 64'(o_cnt[0]), 64'd0);
        chk("reset alarm", 64'(o_alarm[0]), 64'd0);
        rst = 1'b0;

        // T1: one beat on channel 0, matching ready everywhere.
        en = 1'b1; nr = 2'b11; cr = 2'b11;
        nv = 2'b01; nd[0] = 32'hA5A5_0001; ns[0] = 4'hF;
        cycle();
        chk("T1 copy data", 64'(o_cd[0][0]), 64'h0000_0000_A5A5_0001);
        chk("T1 copy valid", 64'(o_cv[0]), 64'd1);
        nv = 2'b11; nd[0] = 32'h0000_1111; nd[1] = 32'h2222_0000;
        cycle();
        chk("T1 fault", 64'(o_fault[0]), 64'd0);
        chk("T1 count", 64'(o_cnt[0]), 64'd0);

        // T2: drop ch1 copy ready once while the delayed beat is valid.
        cr = 2'b01;
        cycle();
        chk("T2 fault", 64'(o_fault[0]), 64'b10);
        chk("T2 sticky", 64'(o_sticky[0]), 64'b10);
        chk("T2 count", 64'(o_cnt[0]), 64'd1);
        chk("T2 alarm", 64'(o_alarm[0]), 64'd0);
        cr = 2'b11;
        cycle();

        // T3: three more mismatches reach the threshold of 4.
        for (int k = 0; k < 3; k++) begin
            cr = 2'b01; cycle();
            cr = 2'b11; cycle();
        end
        chk("T3 count", 64'(o_cnt[0]), 64'd4);
        chk("T3 alarm", 64'(o_alarm[0]), 64'd1);
        clr_c = 1'b1; cycle(); clr_c = 1'b0;
        chk("T3 clr count", 64'(o_cnt[0]), 64'd0);
        chk("T3 clr alarm", 64'(o_alarm[0]), 64'd0);

        // T4: clear racing a new mismatch keeps sticky; clear alone drops it.
        cr = 2'b01; clr_f = 2'b10; cycle();
        chk("T4 sticky set wins", 64'(o_sticky[0][1]), 64'd1);
        cr = 2'b11; cycle(); clr_f = 2'b00;
        chk("T4 sticky cleared", 64'(o_sticky[0][1]), 64'd0);

        // T5: saturation of the 3-bit counter, then valid gating.
        cr = 2'b01;
        for (int k = 0; k < 10; k++) cycle();
        chk("T5 count sat", 64'(o_cnt[0]), 64'd7);
        nv = 2'b00; cr = 2'b11; cycle(); cycle();
        cr = 2'b01; cycle();
        chk("T5 valid gated", 64'(o_fault[0]), 64'd0);

        // T6: disabled compare holds counter; then reset mid-stream.
        nv = 2'b11; cr = 2'b11; cycle(); cycle(); cycle();
        en = 1'b0; cr = 2'b00; cycle();
        chk("T6 disabled fault", 64'(o_fault[0]), 64'd0);
        chk("T6 disabled count", 64'(o_cnt[0]), 64'd7);
        en = 1'b1; cr = 2'b11; nd[1] = 32'hDEAD_BEEF;
        rst = 1'b1; cycle();
        chk("T6 rst copy valid", 64'(o_cv[0]), 64'd0);
        chk("T6 rst count", 64'(o_cnt[0]), 64'd0);
        chk("T6 rst sticky", 64'(o_sticky[0]), 64'd0);
        rst = 1'b0; cycle();
        chk("T6 post-rst valid D2", 64'(o_cv[1]), 64'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 200; k++) begin
            nv    = 2'($urandom());
            nr    = 2'($urandom());
            nd[0] = $urandom(); nd[1] = $urandom();
            ns    = 8'($urandom());
            cr    = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : nr;
            en    = ($urandom_range(0, 7) != 0);
            clr_f = ($urandom_range(0, 5) == 0) ? 2'($urandom()) : 2'b00;
            clr_c = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
